// File: rtl/synchronizer_bank_pkg.sv
// Shared types and helpers for the synchronizer bank and its per-channel filter.
package sync_pkg;

  // Filter view of a channel: STABLE while the synchronized input matches the
  // accepted level, QUALIFYING while a new value is trying to persist.
  typedef enum logic {
    STABLE     = 1'b0,
    QUALIFYING = 1'b1
  } filter_state_e;

  // Persistence counter must be able to hold 0..FILTER_CYCLES.
  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/glitch_filter_channel.sv
// Single-bit stability filter with registered rise/fall pulses.
// A new synchronized value is accepted only after it has persisted for
// FILTER_CYCLES consecutive enabled cycles; any reversion restarts the count.
module glitch_filter_channel
  import sync_pkg::*;
#(
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk_i,
  input  logic async_rst_n_i,
  input  logic clk_en_i,
  input  logic sync_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  filter_state_e state;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d, rise_d, fall_d;

  // State is implied by the comparison; kept as an enum so it reads on a waveform.
  assign state = (sync_i != level_o) ? QUALIFYING : STABLE;

  // Next-state: count persistence, accept on the last qualifying cycle, pulse once.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_o;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (clk_en_i) begin
      case (state)
        STABLE: cnt_d = '0;
        QUALIFYING: begin
          if (cnt_q == LAST) begin
            level_d = sync_i;
            cnt_d   = '0;
            rise_d  = sync_i;
            fall_d  = ~sync_i;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Filter registers; pulses are registered so they align with the new level.
  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      cnt_q   <= '0;
      level_o <= RESET_LEVEL;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_o <= level_d;
      rise_o  <= rise_d;
      fall_o  <= fall_d;
    end
  end

endmodule

// File: rtl/synchronizer_bank.sv
// Multi-channel input conditioner: flop-chain synchronizer, glitch filter and
// edge pulses per channel. The sync chain free-runs; clk_en_i only gates filtering.
module synchronizer_bank
  import sync_pkg::*;
#(
  parameter int                  CHANNELS      = 8,
  parameter int                  SYNC_DEPTH    = 3,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
  input  logic                clk_i,
  input  logic                async_rst_n_i,
  input  logic                clk_en_i,
  input  logic [CHANNELS-1:0] async_i,
  output logic [CHANNELS-1:0] raw_sync_o,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o
);

  logic [CHANNELS-1:0] sync_q [SYNC_DEPTH];

  for (genvar s = 0; s < SYNC_DEPTH; s++) begin : g_sync
    if (s == 0) begin : g_first
      // First stage samples the asynchronous pins.
      always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) sync_q[0] <= RESET_VALUE;
        else                sync_q[0] <= async_i;
      end
    end else begin : g_next
      // Remaining stages shift every edge, never stalled by clk_en_i.
      always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) sync_q[s] <= RESET_VALUE;
        else                sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign raw_sync_o = sync_q[SYNC_DEPTH-1];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    glitch_filter_channel #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_LEVEL   (RESET_VALUE[c])
    ) u_filt (
      .clk_i         (clk_i),
      .async_rst_n_i (async_rst_n_i),
      .clk_en_i      (clk_en_i),
      .sync_i        (raw_sync_o[c]),
      .level_o       (level_o[c]),
      .rise_o        (rise_o[c]),
      .fall_o        (fall_o[c])
    );
  end

endmodule

// File: tb/tb_synchronizer_bank.sv
// Bench for synchronizer_bank: directed vector table for the corner cases,
// then randomized stimulus compared against a persistence-streak model.
module tb_synchronizer_bank;

  localparam int         CH = 4;
  localparam int         SD = 2;
  localparam int         FC = 3;
  localparam logic [3:0] RV = 4'b0101;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [CH-1:0] a;
  logic [CH-1:0] raw, lvl, rise, fall;

  int n_chk  = 0;
  int n_fail = 0;

  synchronizer_bank #(
    .CHANNELS      (CH),
    .SYNC_DEPTH    (SD),
    .FILTER_CYCLES (FC),
    .RESET_VALUE   (RV)
  ) dut (
    .clk_i         (clk),
    .async_rst_n_i (rst_n),
    .clk_en_i      (en),
    .async_i       (a),
    .raw_sync_o    (raw),
    .level_o       (lvl),
    .rise_o        (rise),
    .fall_o        (fall)
  );

  always #5 clk = ~clk;

  // Reference: raw is the input as sampled SD edges ago; a channel adopts the
  // raw value once it has differed from the level for FC enabled cycles in a row.
  logic [CH-1:0] m_hist [SD];
  logic [CH-1:0] m_level, m_rise, m_fall;
  int            m_streak [CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SD; s++) m_hist[s] <= RV;
      for (int c = 0; c < CH; c++) m_streak[c] <= 0;
      m_level <= RV;
      m_rise  <= '0;
      m_fall  <= '0;
    end else begin
      m_hist[0] <= a;
      for (int s = 1; s < SD; s++) m_hist[s] <= m_hist[s-1];
      m_rise <= '0;
      m_fall <= '0;
      if (en) begin
        for (int c = 0; c < CH; c++) begin
          if (m_hist[SD-1][c] == m_level[c]) begin
            m_streak[c] <= 0;
          end else if (m_streak[c] + 1 >= FC) begin
            m_level[c]  <= m_hist[SD-1][c];
            m_streak[c] <= 0;
            if (m_hist[SD-1][c]) m_rise[c] <= 1'b1;
            else                 m_fall[c] <= 1'b1;
          end else begin
            m_streak[c] <= m_streak[c] + 1;
          end
        end
      end
    end
  end

  typedef struct {
    logic          rst_n;
    logic          en;
    logic [CH-1:0] a;
    logic [CH-1:0] raw, lvl, rise, fall;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic e, input logic [3:0] ai,
                     input logic [3:0] xr, input logic [3:0] xl,
                     input logic [3:0] xri, input logic [3:0] xf);
    vec_t v;
    v.rst_n = r; v.en = e; v.a = ai;
    v.raw = xr; v.lvl = xl; v.rise = xri; v.fall = xf;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; a = RV;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_level", 0, lvl, RV);
    chk("idle_raw", 0, raw, RV);

    // Mid-cycle reset with inputs opposite to the reset value.
    a = 4'b1010;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_raw", 0, raw, RV);
    chk("rst_level", 0, lvl, RV);
    chk("rst_rise", 0, rise, 4'b0000);
    chk("rst_fall", 0, fall, 4'b0000);

    // Reset release: every channel qualifies, flips at edge 5.
    row(0,1,4'b1010, 4'b0101,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b0101,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1010,4'b1010,4'b0101);
    row(1,1,4'b1010, 4'b1010,4'b1010,4'b0000,4'b0000);
    // Clean fall on ch1.
    row(1,1,4'b1000, 4'b1010,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1000, 4'b1000,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1000, 4'b1000,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1000, 4'b1000,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1000, 4'b1000,4'b1000,4'b0000,4'b0010);
    row(1,1,4'b1000, 4'b1000,4'b1000,4'b0000,4'b0000);
    // Rise on ch1 with the enable dropped for edges 4..7: accepted at edge 9.
    row(1,1,4'b1010, 4'b1000,4'b1000,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1000,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1000,4'b0000,4'b0000);
    row(1,0,4'b1010, 4'b1010,4'b1000,4'b0000,4'b0000);
    row(1,0,4'b1010, 4'b1010,4'b1000,4'b0000,4'b0000);
    row(1,0,4'b1010, 4'b1010,4'b1000,4'b0000,4'b0000);
    row(1,0,4'b1010, 4'b1010,4'b1000,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1000,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1010,4'b0010,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1010,4'b0000,4'b0000);
    // Two-cycle glitch on ch0: raw shows it, level never does.
    row(1,1,4'b1011, 4'b1010,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1011, 4'b1011,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1011,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1010,4'b0000,4'b0000);
    // Simultaneous: ch0 rises / ch1 falls, then ch1 rises / ch0 falls.
    row(1,1,4'b1001, 4'b1010,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1001, 4'b1001,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1001, 4'b1001,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1001, 4'b1001,4'b1010,4'b0000,4'b0000);
    row(1,1,4'b1001, 4'b1001,4'b1001,4'b0001,4'b0010);
    row(1,1,4'b1001, 4'b1001,4'b1001,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1001,4'b1001,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1001,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1001,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1001,4'b0000,4'b0000);
    row(1,1,4'b1010, 4'b1010,4'b1010,4'b0010,4'b0001);
    row(1,0,4'b1010, 4'b1010,4'b1010,4'b0000,4'b0000);
    // Reset while ch1 is qualifying: count discarded, re-qualifies from release.
    row(0,1,4'b0101, 4'b0101,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0101, 4'b0101,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0101, 4'b0101,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0111, 4'b0101,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0111, 4'b0111,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0111, 4'b0111,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0111, 4'b0111,4'b0101,4'b0000,4'b0000);
    row(0,1,4'b0111, 4'b0101,4'b0101,4'b0000,4'b0000);
    row(0,1,4'b0111, 4'b0101,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0111, 4'b0101,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0111, 4'b0111,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0111, 4'b0111,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0111, 4'b0111,4'b0101,4'b0000,4'b0000);
    row(1,1,4'b0111, 4'b0111,4'b0111,4'b0010,4'b0000);
    row(1,1,4'b0111, 4'b0111,4'b0111,4'b0000,4'b0000);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; en = tbl[i].en; a = tbl[i].a;
      @(posedge clk);
      #2;
      chk("vec_raw", i, raw, tbl[i].raw);
      chk("vec_level", i, lvl, tbl[i].lvl);
      chk("vec_rise", i, rise, tbl[i].rise);
      chk("vec_fall", i, fall, tbl[i].fall);
    end

    // Randomized phase: sparse toggles give both glitches and long runs.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 3) == 0) a[c] = ~a[c];
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      @(posedge clk);
      #2;
      chk("rnd_raw", n, raw, m_hist[SD-1]);
      chk("rnd_level", n, lvl, m_level);
      chk("rnd_rise", n, rise, m_rise);
      chk("rnd_fall", n, fall, m_fall);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
